// File: rtl/opcode_stream_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : opcode_stream_parser_if
// Description : Byte-stream, opcode-lookup and descriptor bundle for the
//               x86-64 opcode stream parser.
// Revision    : 1.0
// ============================================================================
interface opcode_stream_parser_if #(
  parameter int IN_BYTES = 4
);
  localparam int CNT_W = $clog2(IN_BYTES + 1);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_BYTES*8-1:0] in_bytes;
  logic [CNT_W-1:0]      in_count;

  logic [1:0]            lk_map;
  logic [7:0]            lk_opcode;
  logic                  lk_needs_modrm;

  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_prefix;
  logic [2:0]            out_seg;
  logic                  out_lock;
  logic [3:0]            out_rex;
  logic [1:0]            out_map;
  logic [7:0]            out_opcode;
  logic                  out_has_modrm;
  logic [7:0]            out_modrm;
  logic [3:0]            out_len;
  logic                  out_err;

  // Environment side: fetch stream, opcode tables and descriptor consumer.
  modport master (
    output flush, in_valid, in_bytes, in_count, lk_needs_modrm, out_ready,
    input  in_ready, lk_map, lk_opcode, out_valid, out_prefix, out_seg,
           out_lock, out_rex, out_map, out_opcode, out_has_modrm, out_modrm,
           out_len, out_err
  );

  // Parser side.
  modport slave (
    input  flush, in_valid, in_bytes, in_count, lk_needs_modrm, out_ready,
    output in_ready, lk_map, lk_opcode, out_valid, out_prefix, out_seg,
           out_lock, out_rex, out_map, out_opcode, out_has_modrm, out_modrm,
           out_len, out_err
  );
endinterface
`default_nettype wire

// File: rtl/opcode_stream_parser.sv
`default_nettype none
// ============================================================================
// Module      : opcode_stream_parser
// Description : Buffers x86-64 instruction bytes and parses prefixes, REX,
//               escapes, opcode and ModRM into one descriptor per instruction.
// Revision    : 1.0
// ============================================================================
module opcode_stream_parser #(
  parameter int IN_BYTES  = 4,
  parameter int BUF_BYTES = 16,
  parameter int MAX_LEN   = 15
) (
  input wire                    clk,
  input wire                    reset,
  opcode_stream_parser_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = $clog2(BUF_BYTES + 1);
  localparam int INC_W = $clog2(IN_BYTES + 1);
  localparam logic [3:0]       MAX_LEN_C = 4'(MAX_LEN);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_BYTES - IN_BYTES);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_PREFIX = 3'd1,
    ST_ESC    = 3'd2,
    ST_ESC2   = 3'd3,
    ST_MODRM  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] prefix;
    logic [2:0] seg;
    logic       lock;
    logic [3:0] rex;
    logic [1:0] map;
    logic [7:0] opcode;
    logic       has_modrm;
    logic [7:0] modrm;
    logic [3:0] len;
    logic       err;
  } desc_t;

  logic [7:0]       mem_q [BUF_BYTES];
  logic [7:0]       mem_d [BUF_BYTES];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  desc_t            cur_q, cur_d;
  desc_t            out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic             push;
  logic             pop;
  logic [7:0]       head_byte;
  logic [1:0]       lk_map_c;
  logic [7:0]       lk_opcode_c;
  desc_t            nxt;
  logic             op_cyc;
  logic             legacy;
  logic             complete;

  assign bus.in_ready = (count_q <= READY_MAX);
  assign push      = bus.in_valid && bus.in_ready && (bus.in_count != '0);
  assign pop       = (count_q != '0) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign head_byte = mem_q[head_q];

  // Byte buffer: push of in_count bytes at tail, pop of one byte at head.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        for (int i = 0; i < IN_BYTES; i++) begin
          if (INC_W'(i) < bus.in_count) begin
            mem_d[tail_q + PTR_W'(i)] = bus.in_bytes[8*i +: 8];
          end
        end
        tail_d = tail_q + PTR_W'(bus.in_count);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + (push ? CNT_W'(bus.in_count) : CNT_W'(0))
                        - (pop  ? CNT_W'(1)            : CNT_W'(0));
    end
  end

  // Parser: absorbs the head byte into 'nxt', then either completes or keeps it.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    lk_map_c    = 2'd0;
    lk_opcode_c = 8'd0;
    nxt         = cur_q;
    op_cyc      = 1'b0;
    legacy      = 1'b0;
    complete    = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_d       = '0;
    end

    if (pop) begin
      nxt.len = cur_q.len + 4'd1;
      case (state_q)
        ST_START, ST_PREFIX: begin
          state_d = ST_PREFIX;
          case (head_byte)
            8'h66: begin nxt.prefix[0] = 1'b1; legacy = 1'b1; end
            8'h67: begin nxt.prefix[1] = 1'b1; legacy = 1'b1; end
            8'hF2: begin nxt.prefix[2] = 1'b1; legacy = 1'b1; end
            8'hF3: begin nxt.prefix[3] = 1'b1; legacy = 1'b1; end
            8'hF0: begin nxt.lock      = 1'b1; legacy = 1'b1; end
            8'h26: begin nxt.seg = 3'd1; legacy = 1'b1; end
            8'h2E: begin nxt.seg = 3'd2; legacy = 1'b1; end
            8'h36: begin nxt.seg = 3'd3; legacy = 1'b1; end
            8'h3E: begin nxt.seg = 3'd4; legacy = 1'b1; end
            8'h64: begin nxt.seg = 3'd5; legacy = 1'b1; end
            8'h65: begin nxt.seg = 3'd6; legacy = 1'b1; end
            8'h0F: begin nxt.map = 2'd1; state_d = ST_ESC; end
            default: begin
              if (head_byte[7:4] == 4'h4) begin
                nxt.rex = head_byte[3:0];
              end else begin
                op_cyc = 1'b1;
              end
            end
          endcase
          // REX is only meaningful directly in front of the opcode.
          if (legacy) begin
            nxt.rex = 4'd0;
          end
        end
        ST_ESC: begin
          case (head_byte)
            8'h38:   begin nxt.map = 2'd2; state_d = ST_ESC2; end
            8'h3A:   begin nxt.map = 2'd3; state_d = ST_ESC2; end
            default: op_cyc = 1'b1;
          endcase
        end
        ST_ESC2: begin
          op_cyc = 1'b1;
        end
        ST_MODRM: begin
          nxt.modrm = head_byte;
          complete  = 1'b1;
        end
        default: begin
          state_d = ST_START;
        end
      endcase

      if (op_cyc) begin
        lk_map_c    = nxt.map;
        lk_opcode_c = head_byte;
        nxt.opcode  = head_byte;
        if (bus.lk_needs_modrm) begin
          nxt.has_modrm = 1'b1;
          state_d       = ST_MODRM;
        end else begin
          complete = 1'b1;
        end
      end

      if (complete || (nxt.len == MAX_LEN_C)) begin
        out_d       = nxt;
        out_d.err   = !complete;
        out_valid_d = 1'b1;
        cur_d       = '0;
        state_d     = ST_START;
      end else begin
        cur_d = nxt;
      end
    end

    if (bus.flush) begin
      state_d     = ST_START;
      cur_d       = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q       <= '{default: 8'h00};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_START;
      cur_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cur_q       <= cur_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.lk_map        = lk_map_c;
  assign bus.lk_opcode     = lk_opcode_c;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_prefix    = out_q.prefix;
  assign bus.out_seg       = out_q.seg;
  assign bus.out_lock      = out_q.lock;
  assign bus.out_rex       = out_q.rex;
  assign bus.out_map       = out_q.map;
  assign bus.out_opcode    = out_q.opcode;
  assign bus.out_has_modrm = out_q.has_modrm;
  assign bus.out_modrm     = out_q.modrm;
  assign bus.out_len       = out_q.len;
  assign bus.out_err       = out_q.err;

  a_in_count_nonzero: assert property (@(posedge clk) disable iff (reset)
    (bus.in_valid && bus.in_ready) |-> (bus.in_count != '0));

endmodule
`default_nettype wire

// File: doc/opcode_stream_parser.md
Name: opcode_stream_parser

Overview:
- Streaming front end of the x86-64 decode stage. Sits between the fetch byte stream and the operand/immediate decoder.
- Buffers incoming instruction bytes, then parses them one byte per cycle: legacy prefixes, REX, opcode escapes (0F, 0F 38, 0F 3A), the opcode byte and an optional ModRM byte.
- Emits one registered opcode descriptor per instruction over a valid/ready handshake.
- Whether an opcode takes ModRM comes from a combinational lookup side port served by the opcode tables.

Parameters:
IN_BYTES, 4, bytes offered per input beat (1..8)
BUF_BYTES, 16, internal byte-buffer depth (power of 2, >= 2*IN_BYTES)
MAX_LEN, 15, maximum bytes parsed per instruction before error

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous: empty buffer, return FSM to START, drop pending output
in_valid  in  1  input beat valid
in_ready  out  1  buffer has >= IN_BYTES free slots
in_bytes  in  IN_BYTES*8  byte 0 in bits [7:0]; byte 0 is the oldest
in_count  in  $clog2(IN_BYTES+1)  valid bytes in beat (1..IN_BYTES)
lk_map  out  2  lookup map: 0=1-byte, 1=0F, 2=0F38, 3=0F3A
lk_opcode  out  8  lookup opcode (current head byte)
lk_needs_modrm  in  1  combinational reply, same cycle
out_valid  out  1  descriptor valid
out_ready  in  1  consumer accepts
out_prefix  out  4  {F3,F2,67,66} seen
out_seg  out  3  last segment override: 0 none, 1..6 = 26,2E,36,3E,64,65
out_lock  out  1  F0 seen
out_rex  out  4  {W,R,X,B}
out_map  out  2  as lk_map
out_opcode  out  8  final opcode byte
out_has_modrm  out  1  ModRM present
out_modrm  out  8  ModRM byte (0 if absent)
out_len  out  4  bytes consumed, prefixes through ModRM
out_err  out  1  MAX_LEN exceeded

Behaviour:
- Reset (async): buffer empty; FSM=START; every out_* = 0; in_ready=1; lk_* = 0.
- Buffer: circular, with head/tail pointers and a count. A push of in_count bytes and a pop of one byte may happen in the same cycle. Push occurs on in_valid && in_ready. in_count=0 is illegal: an assertion fires and nothing is pushed.
- Parser consumes at most one head byte per cycle, and only when the buffer is non-empty and the output register is free (!out_valid || out_ready).
- FSM states and transitions:
  - START/PREFIX:
    - Legacy prefix: set its bit. Segment bytes overwrite out_seg. A legacy prefix clears any REX already captured, because REX counts only immediately before the opcode.
    - 40-4F: capture REX low nibble; stay in PREFIX.
    - 0F: go to ESC.
    - Any other byte: opcode with map 0.
  - ESC:
    - 38: go to ESC2 with map 2.
    - 3A: go to ESC2 with map 3.
    - Any other byte: opcode with map 1.
  - ESC2: next byte is the opcode.
  - Opcode consume: drive lk_map/lk_opcode from the state and head byte; sample lk_needs_modrm.
    - If set: go to MODRM.
    - Else: complete.
  - MODRM: consume the byte into out_modrm; complete.
- Complete: load the output register; out_valid=1 the next cycle; the FSM returns to START in the same cycle. Parse latency is len cycles plus 1 cycle to out_valid, assuming bytes are available.
- Output register holds stable while out_valid && !out_ready. It clears or reloads on a handshake. Back-to-back instructions sustain 1 byte/cycle.
- Length: an internal counter increments per consumed byte.
  - If the counter reaches MAX_LEN without completion, emit a descriptor with out_err=1 and out_len=MAX_LEN; the other fields hold whatever was captured so far. The FSM returns to START.
  - The MAX_LEN-th byte is consumed. A completion on exactly the MAX_LEN-th byte is legal and sets out_err=0.
- Empty buffer mid-instruction: the FSM holds its state and partial fields; no timeout.
- flush has priority over push and pop in the same cycle. in_ready stays combinational from the count. A descriptor completing in the flush cycle is dropped.
- Reset mid-parse: asynchronously clears everything, as at reset.
- lk_* = 0 when not in an opcode-consume cycle.

Test Plan:
- Push 48 89 E5, lk_needs_modrm=1 for (0,89) -> rex=1000, map=0, opcode=89, has_modrm=1, modrm=E5, len=3, err=0; out_valid 4 cycles after first byte available.
- Push 0F 05, lk_needs_modrm=0 -> map=1, opcode=05, has_modrm=0, modrm=00, len=2.
- Push 66 64 0F 38 00 C1, lk_needs_modrm=1 -> prefix=0001, seg=5, map=2, opcode=00, modrm=C1, len=6.
- Push 48 66 89 C0 -> rex=0000 (cancelled), prefix=0001, opcode=89, len=4; then 66 48 89 C0 -> rex=1000.
- Push sixteen 66 bytes -> first descriptor err=1, len=15; next parse begins at the 16th byte.
- IN_BYTES=4: stream 8 two-byte instructions with out_ready low for 6 cycles -> descriptor held stable, in_ready falls at 13+ bytes buffered, all 8 descriptors emitted in order with no loss. Assert reset mid-ESC -> all outputs 0 immediately.
